aes_round_ctrl: RTL and testbench

Sequences one AES-128 encryption through the shared `S_box_ROM`. The ROM performs SubBytes on the 128-bit state and SubWord on the key-schedule word in one access. The block holds the state and round-key registers and drives the ROM every round. It also performs ShiftRows, MixColumns, AddRoundKey and the key expansion around the ROM. A start/busy/done handshake makes it the encryption top's controller.

---
 rtl/aes_round_ctrl_pkg.sv | 34 +++
 rtl/aes_round_ctrl_mix.sv | 23 ++
 rtl/aes_round_ctrl.sv | 90 +++++++++
 tb/tb_aes_round_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 constants, FSM encoding and the byte-level helpers used
// by the round controller and its MixColumns datapath.
package aes_round_ctrl_pkg;

    localparam int TEXT_WIDTH      = 128;
    localparam int FOUR_BYTE_WIDTH = 32;
    localparam int BYTE_WIDTH      = 8;
    localparam int S_BOX_SIZE      = 256;
    localparam int NR              = 10;

    localparam logic [BYTE_WIDTH-1:0] RCON_INIT  = 8'h01;
    localparam logic [BYTE_WIDTH-1:0] XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2
    } fsm_e;

    function automatic logic [BYTE_WIDTH-1:0] xtime(input logic [BYTE_WIDTH-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    // Byte i sits at [127-8i -: 8]; byte index = 4*column + row.
    function automatic logic [TEXT_WIDTH-1:0] shift_rows(input logic [TEXT_WIDTH-1:0] s);
        logic [TEXT_WIDTH-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_mix.sv
// Combinational MixColumns over the full 128-bit state, one generate lane
// per column.
module aes_mix_columns
    import aes_round_ctrl_pkg::*;
(
    input  logic [TEXT_WIDTH-1:0] data_i,
    output logic [TEXT_WIDTH-1:0] data_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [BYTE_WIDTH-1:0] a0, a1, a2, a3;
        assign a0 = data_i[127-32*c -: 8];
        assign a1 = data_i[119-32*c -: 8];
        assign a2 = data_i[111-32*c -: 8];
        assign a3 = data_i[103-32*c -: 8];

        assign data_o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign data_o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign data_o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign data_o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: two cycles per round around an external
// S-box ROM (SUB samples the ROM, MIX finishes the round).
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [TEXT_WIDTH-1:0]      plaintext_i,
    input  logic [TEXT_WIDTH-1:0]      key_i,
    input  logic [TEXT_WIDTH-1:0]      sbox_text_i,
    input  logic [FOUR_BYTE_WIDTH-1:0] sbox_word_i,
    output logic [TEXT_WIDTH-1:0]      sbox_text_o,
    output logic [FOUR_BYTE_WIDTH-1:0] sbox_word_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [TEXT_WIDTH-1:0]      cyphertext_o
);

    fsm_e                  fsm;
    logic [TEXT_WIDTH-1:0] state, rk, tmp;
    logic [3:0]            round;
    logic [BYTE_WIDTH-1:0] rcon;

    logic [FOUR_BYTE_WIDTH-1:0] w0n, w1n, w2n, w3n;
    logic [TEXT_WIDTH-1:0]      sr_tmp, mix_tmp;

    assign sbox_text_o = state;
    assign sbox_word_o = {rk[23:0], rk[31:24]};
    assign busy_o      = (fsm != IDLE);

    // Next round key; sbox_word_i is SubWord(RotWord(w3)) from the ROM.
    assign w0n = rk[127:96] ^ sbox_word_i ^ {rcon, 24'h0};
    assign w1n = rk[95:64]  ^ w0n;
    assign w2n = rk[63:32]  ^ w1n;
    assign w3n = rk[31:0]   ^ w2n;

    assign sr_tmp = shift_rows(tmp);

    aes_mix_columns u_mix (
        .data_i (sr_tmp),
        .data_o (mix_tmp)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fsm          <= IDLE;
            state        <= '0;
            rk           <= '0;
            tmp          <= '0;
            round        <= '0;
            rcon         <= '0;
            cyphertext_o <= '0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_i) begin
                        state <= plaintext_i ^ key_i;
                        rk    <= key_i;
                        round <= 4'd1;
                        rcon  <= RCON_INIT;
                        fsm   <= SUB;
                    end
                end
                SUB: begin
                    tmp <= sbox_text_i;
                    rk  <= {w0n, w1n, w2n, w3n};
                    fsm <= MIX;
                end
                MIX: begin
                    if (round == 4'(NR)) begin
                        state        <= sr_tmp ^ rk;
                        cyphertext_o <= sr_tmp ^ rk;
                        done_o       <= 1'b1;
                        fsm          <= IDLE;
                    end else begin
                        state <= mix_tmp ^ rk;
                        round <= round + 4'd1;
                        rcon  <= xtime(rcon);
                        fsm   <= SUB;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with a behavioural falling-edge S-box ROM;
// known-answer vectors plus handshake, reset and back-to-back sequences.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] pt, key;
    logic [127:0] rom_text;
    logic [31:0]  rom_word;
    logic [127:0] sbox_text_o;
    logic [31:0]  sbox_word_o;
    logic         busy, done;
    logic [127:0] ct;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .plaintext_i  (pt),
        .key_i        (key),
        .sbox_text_i  (rom_text),
        .sbox_word_i  (rom_word),
        .sbox_text_o  (sbox_text_o),
        .sbox_word_o  (sbox_word_o),
        .busy_o       (busy),
        .done_o       (done),
        .cyphertext_o (ct)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box table built from the GF(2^8) inverse (x^254) and the affine map
    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv, b;
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            b = inv;
            sbox_t[v] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) rom_text[127-8*i -: 8] <= sbox_t[sbox_text_o[127-8*i -: 8]];
        for (int i = 0; i < 4; i++)  rom_word[31-8*i -: 8]  <= sbox_t[sbox_word_o[31-8*i -: 8]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Accept one block, scramble inputs afterwards, wait for done (bounded).
    task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                             output int lat, output logic busy_seen);
        key = k; pt = p; start = 1'b1;
        tick();
        start = 1'b0;
        busy_seen = busy;
        key = ~k; pt = ~p;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin lat = n; break; end
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];
    logic [7:0] rcon_tbl [10];

    initial begin
        int           lat;
        logic         bs;
        int           dones;
        int           dn [3];
        logic [127:0] last;
        logic         stable;

        vecs[0] = '{"fips_b",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{"zeros",   128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        rcon_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

        rst_n = 1'b0; start = 1'b0; pt = '0; key = '0;
        tick(); tick();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_ct", ct, 128'd0);
        chk("rst_sbox_text", sbox_text_o, 128'd0);
        chk("rst_sbox_word", 128'(sbox_word_o), 128'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 3; v++) begin
            run_block(vecs[v].key, vecs[v].pt, lat, bs);
            chk({vecs[v].name, "_busy_after_accept"}, 128'(bs), 128'd1);
            chk({vecs[v].name, "_latency"}, 128'(lat), 128'd20);
            chk({vecs[v].name, "_ct"}, ct, vecs[v].ct);
            chk({vecs[v].name, "_busy_at_done"}, 128'(busy), 128'd0);
            tick();
            chk({vecs[v].name, "_done_pulse"}, 128'(done), 128'd0);
        end

        // Key schedule and rcon progression, App. B key
        key = vecs[0].key; pt = vecs[0].pt; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            tick();
            if (r == 1) chk("rk1_rotword", 128'(sbox_word_o), 128'h6c76052a);
            chk($sformatf("rcon_r%0d", r), 128'(dut.rcon), 128'(rcon_tbl[r-1]));
            tick();
        end
        chk("ks_done", 128'(done), 128'd1);
        chk("ks_ct", ct, vecs[0].ct);
        tick();

        // start pulses while busy are dropped
        key = vecs[1].key; pt = vecs[1].pt; start = 1'b1;
        tick();
        dones = 0; last = '0;
        for (int n = 1; n <= 45; n++) begin
            start = (n == 6 || n == 13);
            tick();
            if (done) begin dones++; last = ct; end
        end
        start = 1'b0;
        chk("busy_start_dones", 128'(dones), 128'd1);
        chk("busy_start_ct", last, vecs[1].ct);

        // Mid-run reset aborts without a done
        key = vecs[0].key; pt = vecs[0].pt; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 10; n++) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_ct", ct, 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", 128'(dones), 128'd0);
        run_block(vecs[1].key, vecs[1].pt, lat, bs);
        chk("after_abort_latency", 128'(lat), 128'd20);
        chk("after_abort_ct", ct, vecs[1].ct);
        tick();

        // start held high: one block every 21 cycles
        key = vecs[0].key; pt = vecs[0].pt; start = 1'b1;
        tick();
        dones = 0; stable = 1'b1; dn = '{0, 0, 0};
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (dones > 0 && ct !== vecs[0].ct) stable = 1'b0;
            if (done) begin
                if (dones < 3) dn[dones] = n;
                dones++;
            end
        end
        start = 1'b0;
        chk("b2b_dones", 128'(dones), 128'd3);
        chk("b2b_first", 128'(dn[0]), 128'd20);
        chk("b2b_gap1", 128'(dn[1] - dn[0]), 128'd21);
        chk("b2b_gap2", 128'(dn[2] - dn[1]), 128'd21);
        chk("b2b_ct_stable", 128'(stable), 128'd1);
        chk("b2b_ct", ct, vecs[0].ct);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
